// File: rtl/mc_cpu_if.sv
// mc_cpu_if: instruction and data memory req/ready buses of the multi-cycle core
interface mc_cpu_if #(
  parameter int AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata;
  logic          imem_ready;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata;
  logic [31:0]   dmem_rdata;
  logic          dmem_ready;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_rdata, imem_ready, dmem_rdata, dmem_ready
  );
endinterface

// File: rtl/mc_cpu.sv
// mc_cpu: multi-cycle MIPS-subset core (addu/subu/ori/lui/lw/sw/beq/j) with req/ready memories
module mc_cpu #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int          ADDR_WIDTH     = 32,
  parameter int          TIMEOUT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            reset,
  mc_cpu_if.master        bus,
  output logic            retire,
  output logic [31:0]     retire_pc,
  output logic            halted,
  output logic            error
);
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  state_t state_q, state_d;
  logic run_q, err_q, err_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [31:0] alu_q, alu_d, mdr_q, mdr_d, wait_q, wait_d;
  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, dest;
  logic [15:0] imm16;
  logic [25:0] idx;
  logic is_r, is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, legal;
  logic [31:0] pc_plus4, br_target, alu_y;
  logic req_wait, to_hit;

  assign op    = ir_q[31:26];
  assign rs    = ir_q[25:21];
  assign rt    = ir_q[20:16];
  assign rd    = ir_q[15:11];
  assign funct = ir_q[5:0];
  assign imm16 = ir_q[15:0];
  assign idx   = ir_q[25:0];

  assign is_r    = op == 6'h00;
  assign is_addu = is_r && funct == 6'h21;
  assign is_subu = is_r && funct == 6'h23;
  assign is_ori  = op == 6'h0D;
  assign is_lui  = op == 6'h0F;
  assign is_lw   = op == 6'h23;
  assign is_sw   = op == 6'h2B;
  assign is_beq  = op == 6'h04;
  assign is_j    = op == 6'h02;
  assign legal   = is_addu || is_subu || is_ori || is_lui || is_lw || is_sw || is_beq || is_j;
  assign dest    = is_r ? rd : rt;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {imm_q[29:0], 2'b00};
  assign alu_y     = is_subu ? a_q - b_q :
                     is_ori  ? a_q | imm_q :
                     is_lui  ? {imm_q[15:0], 16'h0000} :
                               a_q + (is_r ? b_q : imm_q);

  // run_q holds fetch off until the first clock edge after reset is released
  assign bus.imem_req   = run_q && state_q == S_FETCH;
  assign bus.imem_addr  = pc_q[ADDR_WIDTH-1:0];
  assign bus.dmem_req   = state_q == S_MEM;
  assign bus.dmem_we    = bus.dmem_req && is_sw;
  assign bus.dmem_addr  = alu_q[ADDR_WIDTH-1:0];
  assign bus.dmem_wdata = b_q;

  assign retire    = (state_q == S_EXEC && (is_beq || is_j)) || state_q == S_WB ||
                     (state_q == S_MEM && is_sw && bus.dmem_ready);
  assign retire_pc = retire ? pc_q : 32'd0;
  assign halted    = state_q == S_HALT;
  assign error     = err_q;

  assign req_wait = (bus.imem_req && !bus.imem_ready) || (bus.dmem_req && !bus.dmem_ready);
  assign to_hit   = TIMEOUT_CYCLES > 0 && req_wait && wait_q == 32'(TIMEOUT_CYCLES - 1);

  // next-state, datapath latches and register-file write for the current phase
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    imm_d   = imm_q;
    alu_d   = alu_q;
    mdr_d   = mdr_q;
    rf_d    = rf_q;
    wait_d  = req_wait ? wait_q + 32'd1 : 32'd0;
    case (state_q)
      S_FETCH: if (bus.imem_req && bus.imem_ready) begin
        ir_d    = bus.imem_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: if (!legal) begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end else begin
        a_d     = rf_q[rs];
        b_d     = rf_q[rt];
        imm_d   = is_ori ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
        state_d = S_EXEC;
      end
      S_EXEC: if (is_beq || is_j) begin
        pc_d    = is_j ? {pc_plus4[31:28], idx, 2'b00} : (a_q == b_q ? br_target : pc_plus4);
        state_d = S_FETCH;
      end else begin
        alu_d   = alu_y;
        state_d = (is_lw || is_sw) ? S_MEM : S_WB;
      end
      S_MEM: if (bus.dmem_ready) begin
        pc_d    = is_sw ? pc_plus4 : pc_q;
        mdr_d   = is_sw ? mdr_q : bus.dmem_rdata;
        state_d = is_sw ? S_FETCH : S_WB;
      end
      S_WB: begin
        rf_d[dest] = is_lw ? mdr_q : alu_q;
        rf_d[0]    = 32'd0;
        pc_d       = pc_plus4;
        state_d    = S_FETCH;
      end
      default: ;
    endcase
    if (to_hit) begin
      state_d = S_HALT;
      err_d   = 1'b1;
    end
  end

  // architectural and sequencing state; reset abandons any in-flight access
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      wait_q  <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      err_q   <= err_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      wait_q  <= wait_d;
      rf_q    <= rf_d;
    end
  end
endmodule

// File: tb/tb_mc_cpu.sv
// tb_mc_cpu: scoreboard bench for mc_cpu with wait-state memory responders
module tb_mc_cpu;
  localparam logic [5:0] OP_ORI = 6'h0D, OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] FN_ADDU = 6'h21, FN_SUBU = 6'h23;
  localparam logic [31:0] ILL = 32'hFC00_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic retire, halted, error;
  logic [31:0] retire_pc;
  always #5 clk = ~clk;

  mc_cpu_if #(.AW(32)) bus();
  mc_cpu #(.RESET_PC(32'h0000_3000), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .retire(retire), .retire_pc(retire_pc), .halted(halted), .error(error)
  );

  typedef struct { logic [31:0] pc; int gap; } rt_t;
  typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
  rt_t rq[$];
  st_t sq[$];
  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  int iw = 0, dw = 0, icnt = 0, dcnt = 0;
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last = 0, dreq_cyc = 0;

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction
  function automatic logic [31:0] enc_j(input logic [25:0] idx);
    return {6'h02, idx};
  endfunction

  // memory responders: ready after iw/dw wait cycles of an asserted request
  initial begin
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.dmem_ready = 1'b0; bus.dmem_rdata = '0;
    for (int k = 0; k < 256; k++) dmem[k] = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.imem_req && !reset) begin
        bus.imem_rdata = imem[bus.imem_addr[9:2]];
        bus.imem_ready = icnt >= iw;
        icnt = bus.imem_ready ? 0 : icnt + 1;
      end else begin
        bus.imem_ready = 1'b0;
        icnt = 0;
      end
      if (bus.dmem_req && !reset) begin
        bus.dmem_ready = dcnt >= dw;
        dcnt = bus.dmem_ready ? 0 : dcnt + 1;
        if (bus.dmem_ready && bus.dmem_we) dmem[bus.dmem_addr[9:2]] = bus.dmem_wdata;
        bus.dmem_rdata = dmem[bus.dmem_addr[9:2]];
      end else begin
        bus.dmem_ready = 1'b0;
        dcnt = 0;
      end
    end
  end

  task automatic push_rt(input logic [31:0] pc, input int gap);
    rt_t e;
    e.pc = pc; e.gap = gap;
    rq.push_back(e);
  endtask
  task automatic push_st(input logic [31:0] a, input logic [31:0] d);
    st_t e;
    e.a = a; e.d = d;
    sq.push_back(e);
  endtask

  task automatic tick;
    rt_t e;
    st_t s;
    @(negedge clk);
    if (reset) begin cyc = 0; last = 0; end else cyc++;
    if (bus.dmem_req) dreq_cyc++;
    if (retire) begin
      n_tests++;
      if (rq.size() == 0) begin
        n_fail++;
        $display("FAIL retire_unexpected: got pc %h, none expected", retire_pc);
      end else begin
        e = rq.pop_front();
        if (retire_pc !== e.pc || cyc - last !== e.gap || halted !== 1'b0) begin
          n_fail++;
          $display("FAIL retire: got pc %h gap %0d halted %b, want pc %h gap %0d halted 0",
                   retire_pc, cyc - last, halted, e.pc, e.gap);
        end
      end
      last = cyc;
    end
    if (bus.dmem_req && bus.dmem_we && bus.dmem_ready) begin
      n_tests++;
      if (sq.size() == 0) begin
        n_fail++;
        $display("FAIL store_unexpected: got addr %h data %h", bus.dmem_addr, bus.dmem_wdata);
      end else begin
        s = sq.pop_front();
        if (bus.dmem_addr !== s.a || bus.dmem_wdata !== s.d) begin
          n_fail++;
          $display("FAIL store: got addr %h data %h, want addr %h data %h", bus.dmem_addr, bus.dmem_wdata, s.a, s.d);
        end
      end
    end
  endtask

  task automatic clear_imem;
    for (int k = 0; k < 256; k++) imem[k] = ILL;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    dreq_cyc = 0;
  endtask

  task automatic run(input int budget, input bit want_halt);
    int k;
    for (k = 0; k < budget; k++) begin
      if (rq.size() == 0 && sq.size() == 0 && (!want_halt || halted)) break;
      tick();
    end
    n_tests++;
    if (k == budget) begin
      n_fail++;
      $display("FAIL run_timeout: got %0d retires and %0d stores pending, want 0", rq.size(), sq.size());
    end
  endtask

  task automatic test_reset;
    iw = 0; dw = 0;
    clear_imem();
    reset = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || retire !== 1'b0 ||
        retire_pc !== 32'd0 || halted !== 1'b0 || error !== 1'b0 || bus.dmem_addr !== 32'd0 || bus.dmem_wdata !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ireq %b dreq %b we %b ret %b rpc %h halt %b err %b daddr %h wdata %h, want all 0",
               bus.imem_req, bus.dmem_req, bus.dmem_we, retire, retire_pc, halted, error, bus.dmem_addr, bus.dmem_wdata);
    end
    n_tests++;
    if (bus.imem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL reset_pc: got %h, want 00003000", bus.imem_addr);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL req_before_edge: got %b, want 0", bus.imem_req);
    end
    tick();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL first_fetch: got req %b addr %h, want req 1 addr 00003000", bus.imem_req, bus.imem_addr);
    end
    run(50, 1'b1);
    n_tests++;
    if (halted !== 1'b1 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prog_halt: got halted %b error %b, want 1 1", halted, error);
    end
  endtask

  task automatic test_alu;
    iw = 0; dw = 0;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 1, 16'd5);
    imem[1] = enc_i(OP_ORI, 0, 2, 16'd7);
    imem[2] = enc_r(1, 2, 3, FN_ADDU);
    imem[3] = enc_i(OP_SW, 0, 3, 16'h0010);
    push_rt(32'h3000, 4); push_rt(32'h3004, 4); push_rt(32'h3008, 4); push_rt(32'h300C, 4);
    push_st(32'h10, 32'd12);
    do_reset();
    run(200, 1'b1);
    n_tests++;
    if (halted !== 1'b1 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_halt: got halted %b error %b, want 1 1", halted, error);
    end
  endtask

  task automatic test_mem;
    iw = 0; dw = 3;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 3, 16'd12);
    imem[1] = enc_i(OP_SW, 0, 3, 16'h0000);
    imem[2] = enc_i(OP_LW, 0, 4, 16'h0000);
    imem[3] = enc_i(OP_SW, 0, 4, 16'h0004);
    push_rt(32'h3000, 4); push_rt(32'h3004, 7); push_rt(32'h3008, 8); push_rt(32'h300C, 7);
    push_st(32'h0, 32'd12); push_st(32'h4, 32'd12);
    do_reset();
    run(200, 1'b1);
    n_tests++;
    if (dreq_cyc !== 12) begin
      n_fail++;
      $display("FAIL dmem_req_cycles: got %0d, want 12", dreq_cyc);
    end
    dw = 0;
  endtask

  task automatic test_branch;
    iw = 0; dw = 0;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 1, 16'd1);
    imem[1] = enc_i(OP_BEQ, 1, 0, 16'd2);
    imem[2] = enc_j(26'hC03);
    imem[3] = enc_i(OP_BEQ, 1, 1, 16'hFFFF);
    push_rt(32'h3000, 4); push_rt(32'h3004, 3); push_rt(32'h3008, 3);
    push_rt(32'h300C, 3); push_rt(32'h300C, 3); push_rt(32'h300C, 3);
    do_reset();
    run(200, 1'b0);
    clear_imem();
    imem[0] = enc_i(OP_BEQ, 0, 0, 16'd2);
    imem[3] = enc_j(26'hC00);
    push_rt(32'h3000, 3); push_rt(32'h300C, 3); push_rt(32'h3000, 3); push_rt(32'h300C, 3);
    do_reset();
    run(200, 1'b0);
    n_tests++;
    if (halted !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_loop_halted: got %b, want 0", halted);
    end
  endtask

  task automatic test_zero;
    iw = 0; dw = 0;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 1, 16'd5);
    imem[1] = enc_i(OP_ORI, 0, 2, 16'd7);
    imem[2] = enc_r(1, 2, 0, FN_ADDU);
    imem[3] = enc_r(0, 1, 5, FN_SUBU);
    imem[4] = enc_i(OP_SW, 0, 5, 16'h0008);
    imem[5] = enc_i(OP_SW, 0, 0, 16'h000C);
    for (int k = 0; k < 6; k++) push_rt(32'h3000 + 32'(4 * k), 4);
    push_st(32'h8, 32'hFFFF_FFFB); push_st(32'hC, 32'h0);
    do_reset();
    run(200, 1'b1);
  endtask

  task automatic test_back_to_back;
    iw = 2; dw = 1;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 1, 16'h1234);
    imem[1] = enc_i(OP_LUI, 0, 2, 16'hABCD);
    imem[2] = enc_i(OP_ORI, 2, 2, 16'h8000);
    imem[3] = enc_r(1, 2, 3, FN_ADDU);
    imem[4] = enc_i(OP_ORI, 0, 8, 16'h0050);
    imem[5] = enc_i(OP_SW, 8, 3, 16'hFFFC);
    imem[6] = enc_i(OP_LW, 8, 6, 16'hFFFC);
    imem[7] = enc_r(6, 1, 7, FN_SUBU);
    imem[8] = enc_i(OP_SW, 8, 7, 16'h0000);
    push_rt(32'h3000, 6); push_rt(32'h3004, 6); push_rt(32'h3008, 6); push_rt(32'h300C, 6);
    push_rt(32'h3010, 6); push_rt(32'h3014, 7); push_rt(32'h3018, 8); push_rt(32'h301C, 6);
    push_rt(32'h3020, 7);
    push_st(32'h4C, 32'hABCD_9234); push_st(32'h50, 32'hABCD_8000);
    do_reset();
    run(300, 1'b1);
    iw = 0; dw = 0;
  endtask

  task automatic test_illegal;
    iw = 0; dw = 0;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 1, 16'd3);
    imem[1] = enc_r(1, 1, 2, 6'h20);
    imem[2] = enc_i(OP_SW, 0, 1, 16'h0000);
    push_rt(32'h3000, 4);
    do_reset();
    run(100, 1'b1);
    repeat (5) tick();
    n_tests++;
    if (halted !== 1'b1 || error !== 1'b1 || bus.imem_req !== 1'b0 || bus.dmem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_funct: got halted %b error %b ireq %b dreq %b, want 1 1 0 0",
               halted, error, bus.imem_req, bus.dmem_req);
    end
    clear_imem();
    imem[0] = {6'h3F, 26'h0};
    do_reset();
    run(100, 1'b1);
    n_tests++;
    if (halted !== 1'b1 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_op: got halted %b error %b, want 1 1", halted, error);
    end
  endtask

  task automatic test_timeout;
    int n;
    iw = 1000; dw = 0; n = 0;
    clear_imem();
    do_reset();
    for (int k = 0; k < 50; k++) begin
      tick();
      if (halted) break;
      if (bus.imem_req) n++;
    end
    n_tests++;
    if (n !== 8 || halted !== 1'b1 || error !== 1'b1 || bus.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout: got %0d req cycles halted %b error %b req %b, want 8 1 1 0", n, halted, error, bus.imem_req);
    end
    iw = 0;
  endtask

  task automatic test_reset_mid;
    int k;
    iw = 0; dw = 5;
    clear_imem();
    imem[0] = enc_i(OP_ORI, 0, 3, 16'd9);
    imem[1] = enc_i(OP_SW, 0, 3, 16'h0020);
    push_rt(32'h3000, 4);
    do_reset();
    for (k = 0; k < 50; k++) begin
      tick();
      if (bus.dmem_req) break;
    end
    n_tests++;
    if (k == 50 || rq.size() != 0) begin
      n_fail++;
      $display("FAIL reach_mem: got %0d cycles, %0d retires pending, want dmem_req within 50 and 0 pending", k, rq.size());
    end
    repeat (2) tick();
    reset = 1'b1;
    #1;
    n_tests++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0 || bus.imem_req !== 1'b0 || retire !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_mem: got dreq %b we %b ireq %b ret %b, want 0 0 0 0", bus.dmem_req, bus.dmem_we, bus.imem_req, retire);
    end
    dw = 0;
    push_rt(32'h3000, 4); push_rt(32'h3004, 4);
    push_st(32'h20, 32'd9);
    repeat (2) tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3000) begin
      n_fail++;
      $display("FAIL restart_fetch: got req %b addr %h, want 1 00003000", bus.imem_req, bus.imem_addr);
    end
    run(100, 1'b1);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem();
    test_branch();
    test_zero();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
